dlx_mem_slave: RTL and testbench
================================

Name: dlx_mem_slave

Overview:
- Synchronous memory bus slave on the DLX external bus, directly downstream of the DLX control/MAC.
- Consumes the control's bus request (as_N, wr_N) together with the address and data from the datapath.
- Performs a word read or write into an internal RAM after a programmable number of wait states.
- Returns a one-cycle active-low ack_n pulse that releases the control's MAC wait state.

Parameters:
- ADDR_W, 10, word-address width; RAM depth is 2**ADDR_W words of 32 bits.
- WAIT_STATES, 2, cycles between request capture and ack; legal range 0..15.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- AD  in  32  byte address from the DLX; word index = AD[ADDR_W+1:2]; AD[1:0] ignored.
- DO  in  32  write data from the DLX.
- as_N  in  1  address strobe, active low; request present while low.
- wr_N  in  1  0 = write, 1 = read; sampled together with as_N.
- DI  out  32  read data to the DLX MDR.
- ack_n  out  1  transfer acknowledge, active low, exactly one cycle per request.
- busy  out  1  high while a request is captured and not yet acknowledged.
- dbg_addr  in  ADDR_W  bench/debug word address.
- dbg_data  out  32  combinational read of RAM[dbg_addr]; has no effect on the bus.

Behaviour:
- Reset values (asynchronous): ack_n=1, busy=0, DI=0, state=IDLE, wait counter=0.
- RAM contents are neither cleared nor altered by reset.
- IDLE:
  - On the rising edge where as_N=0, capture the word index, wr_N and DO into holding registers.
  - Load counter=WAIT_STATES, set busy=1.
  - If WAIT_STATES=0, go to ACK; otherwise go to WAIT.
- WAIT:
  - Decrement counter each cycle; go to ACK on the edge where counter reaches 1.
  - Changes on AD/DO/wr_N during WAIT are ignored; the captured values are used.
- ACK (exactly one cycle):
  - ack_n=0 in this state.
  - Read: DI is loaded on the edge entering ACK and is valid during the ack_n=0 cycle.
  - Write: RAM is written on the edge leaving ACK.
  - Next state is RECOVER; busy=0 from RECOVER onward.
- RECOVER:
  - Stay until as_N=1 is sampled, then return to IDLE.
  - Prevents a strobe held low from generating a second ack.
- Latency: request sampled at edge N; ack_n low during the cycle after edge N+WAIT_STATES.
  - Example: with WAIT_STATES=2, ack_n goes low at edge N+2 and returns high at edge N+3.
- DI holds its last read value until the next read's ACK; writes leave DI unchanged.
- as_N rising during WAIT (request abandoned):
  - Transaction still completes.
  - ack_n still pulses, and the write still occurs.
  - The FSM then passes RECOVER straight to IDLE.
- Back-to-back requests: minimum spacing is the ACK cycle, then one as_N=1 cycle, then the new as_N=0 cycle.
- Reset asserted mid-WAIT or mid-ACK: the pending write is dropped and no ack is issued.
- After reset release, the FSM is in IDLE; if as_N is already low, it is captured as a new request.
- Counter width is 4 bits; WAIT_STATES>15 is illegal, and elaboration asserts on it.

Decomposition:
- Package dlx_bus_pkg:
  - State encoding: IDLE, WAIT, ACK, RECOVER (2 bits).
  - WORD_W=32.
  - Bus polarity constants (ASSERTED_N=0).
- Sub-module dlx_mem_array:
  - Single-port synchronous-write RAM with asynchronous read.
  - Second asynchronous read port for dbg.
  - Instantiated once.
- All FSM and handshake logic lives in dlx_mem_slave.

Test Plan:
- Write then read, WAIT_STATES=2:
  - as_N=0, wr_N=0, AD=0x0000A000, DO=0x00112233 -> one ack_n low pulse 2 cycles after capture; dbg_addr=0x2800 reads 0x00112233.
  - Read of the same address -> DI=0x00112233 during the ack cycle.
- Strobe held low: as_N kept 0 for 10 cycles after a read -> exactly one ack_n pulse; busy=0 after ACK; FSM stuck in RECOVER until as_N=1.
- WAIT_STATES=0 instance: read of a preloaded word 0x01230123 -> ack_n low in the cycle after the as_N capture edge, with DI=0x01230123.
- Latching: change AD to 0x0000A004 and DO to 0xFFFFFFFF during WAIT of a write to 0x0000A000 -> only word 0x2800 is written, and with the original DO.
- Reset mid-wait: write request to word 5 with DO=0xDEADBEEF, then RESET_N=0 during WAIT -> ack_n stays 1; word 5 is unchanged; DI=0 and busy=0 after reset.
- Back-to-back: lw, one idle cycle, sw to another address -> two ack pulses spaced by latency+2 cycles; both transfers are correct in dbg_data.

Source files
------------

// File: rtl/dlx_bus_pkg.sv
// Shared definitions for the DLX external bus: FSM encoding, word width and strobe polarity.
package dlx_bus_pkg;

   localparam int unsigned WORD_W = 32;
   localparam int unsigned CNT_W  = 4;

   // Bus strobes are active low.
   localparam logic ASSERTED_N = 1'b0;

   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StWait    = 2'd1,
      StAck     = 2'd2,
      StRecover = 2'd3
   } bus_state_e;

endpackage

// File: rtl/dlx_mem_array.sv
// Word RAM: one synchronous write port, one asynchronous bus read port and
// one asynchronous debug read port. Contents have no reset.
module dlx_mem_array import dlx_bus_pkg::*; #(
   parameter int unsigned ADDR_W = 10
) (
   input  logic              clk_i,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [WORD_W-1:0] wdata_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [WORD_W-1:0] rdata_o,
   input  logic [ADDR_W-1:0] dbg_addr_i,
   output logic [WORD_W-1:0] dbg_data_o
);

   localparam int unsigned Depth = 2 ** ADDR_W;

   logic [WORD_W-1:0] mem_q [Depth];

   // Single write port, no reset so contents survive a bus reset.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   // Asynchronous read ports.
   always_comb begin
      rdata_o    = mem_q[raddr_i];
      dbg_data_o = mem_q[dbg_addr_i];
   end

endmodule

// File: rtl/dlx_mem_slave.sv
// DLX external bus memory slave: captures a request on as_N, waits a fixed
// number of cycles, then pulses ack_n for one cycle and completes the word
// read or write into the internal RAM.
module dlx_mem_slave import dlx_bus_pkg::*; #(
   parameter int unsigned ADDR_W      = 10,
   parameter int unsigned WAIT_STATES = 2
) (
   input  logic              CLK,
   input  logic              RESET_N,
   input  logic [31:0]       AD,
   input  logic [31:0]       DO,
   input  logic              as_N,
   input  logic              wr_N,
   output logic [31:0]       DI,
   output logic              ack_n,
   output logic              busy,
   input  logic [ADDR_W-1:0] dbg_addr,
   output logic [31:0]       dbg_data
);

   if (WAIT_STATES > 15) begin : g_ws_check
      $fatal(1, "dlx_mem_slave: WAIT_STATES must be in 0..15");
   end

   localparam logic [CNT_W-1:0] WsCnt = CNT_W'(WAIT_STATES);

   bus_state_e        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q;
   logic              is_wr_q;
   logic [WORD_W-1:0] wdata_q;
   logic [WORD_W-1:0] di_q;

   logic [ADDR_W-1:0] ad_idx;
   logic              capture;
   logic              cur_is_wr;
   logic [ADDR_W-1:0] cur_addr;
   logic              ld_di;
   logic              ram_we;
   logic [WORD_W-1:0] ram_rdata;

   // Byte-lane and out-of-range address bits are not decoded.
   logic unused_ad;
   assign unused_ad = ^{AD[31:ADDR_W+2], AD[1:0]};

   assign ad_idx  = AD[ADDR_W+1:2];
   assign capture = (state_q == StIdle) && (as_N == ASSERTED_N);

   // With zero wait states ACK is entered straight from IDLE, before the
   // holding registers are loaded, so the live bus values must be used.
   assign cur_addr  = (state_q == StIdle) ? ad_idx : addr_q;
   assign cur_is_wr = (state_q == StIdle) ? (wr_N == ASSERTED_N) : is_wr_q;

   assign ld_di  = (state_d == StAck) && (state_q != StAck) && !cur_is_wr;
   assign ram_we = (state_q == StAck) && is_wr_q;

   // State register and wait counter.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q <= StIdle;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic: the ACK edge lands WAIT_STATES edges after capture.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (as_N == ASSERTED_N) begin
               cnt_d   = WsCnt;
               state_d = (WsCnt == '0) ? StAck : StWait;
            end
         end
         StWait: begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
               state_d = StAck;
            end
         end
         StAck: begin
            state_d = StRecover;
         end
         StRecover: begin
            // A strobe still held low must not start a second transfer.
            if (as_N != ASSERTED_N) begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Outputs decoded from the current state.
   always_comb begin
      ack_n = (state_q == StAck) ? ASSERTED_N : ~ASSERTED_N;
      busy  = (state_q == StWait) || (state_q == StAck);
   end

   // Request holding registers; later bus changes are ignored until IDLE.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         addr_q  <= '0;
         is_wr_q <= 1'b0;
         wdata_q <= '0;
      end else if (capture) begin
         addr_q  <= ad_idx;
         is_wr_q <= (wr_N == ASSERTED_N);
         wdata_q <= DO;
      end
   end

   // Read data register, loaded on the edge entering ACK for reads only.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         di_q <= '0;
      end else if (ld_di) begin
         di_q <= ram_rdata;
      end
   end

   assign DI = di_q;

   dlx_mem_array #(
      .ADDR_W (ADDR_W)
   ) u_mem (
      .clk_i      (CLK),
      .we_i       (ram_we),
      .waddr_i    (addr_q),
      .wdata_i    (wdata_q),
      .raddr_i    (cur_addr),
      .rdata_o    (ram_rdata),
      .dbg_addr_i (dbg_addr),
      .dbg_data_o (dbg_data)
   );

endmodule

// File: tb/tb_dlx_mem_slave.sv
// Scoreboard bench for dlx_mem_slave: a WAIT_STATES=2 instance and a
// WAIT_STATES=0 instance share the bus and are checked against one RAM model.
module tb_dlx_mem_slave;

   localparam int unsigned ADDR_W = 14;  // wide enough to decode 0xA000
   localparam int unsigned WS     = 2;

   localparam int ModeNormal  = 0;
   localparam int ModeLatch   = 1;
   localparam int ModeAbandon = 2;
   localparam int ModeHold    = 3;

   logic              CLK = 1'b0;
   logic              RESET_N;
   logic [31:0]       AD, DO;
   logic              as_N, wr_N, en0;
   logic              as0_N;
   logic [ADDR_W-1:0] dbg_addr;
   logic [31:0]       DI, DI0, dbg_data, dbg_data0;
   logic              ack_n, ack0_n, busy, busy0;

   int n_checks = 0;
   int n_pass   = 0;

   logic [31:0] mem_model [int];
   logic [31:0] last_di;
   logic [31:0] sb2 [$];
   logic [31:0] sb0 [$];

   always #5 CLK = ~CLK;

   assign as0_N = as_N | ~en0;

   dlx_mem_slave #(.ADDR_W(ADDR_W), .WAIT_STATES(WS)) dut (
      .CLK(CLK), .RESET_N(RESET_N), .AD(AD), .DO(DO), .as_N(as_N), .wr_N(wr_N),
      .DI(DI), .ack_n(ack_n), .busy(busy), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
   );

   dlx_mem_slave #(.ADDR_W(ADDR_W), .WAIT_STATES(0)) dut0 (
      .CLK(CLK), .RESET_N(RESET_N), .AD(AD), .DO(DO), .as_N(as0_N), .wr_N(wr_N),
      .DI(DI0), .ack_n(ack0_n), .busy(busy0), .dbg_addr(dbg_addr), .dbg_data(dbg_data0)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // Every ack pops the DI value the model predicts for that transfer.
   always @(negedge CLK) begin
      if (RESET_N === 1'b1 && ack_n === 1'b0) begin
         if (sb2.size() == 0) check_eq("ws2_spurious_ack", sb2.size(), 1);
         else check_eq("ws2_di_at_ack", DI, sb2.pop_front());
      end
   end

   always @(negedge CLK) begin
      if (RESET_N === 1'b1 && ack0_n === 1'b0) begin
         if (sb0.size() == 0) check_eq("ws0_spurious_ack", sb0.size(), 1);
         else check_eq("ws0_di_at_ack", DI0, sb0.pop_front());
      end
   end

   task automatic check_dbg(input int idx);
      dbg_addr = idx[ADDR_W-1:0];
      #1;
      check_eq("ws2_dbg_data", dbg_data, mem_model[idx]);
      check_eq("ws0_dbg_data", dbg_data0, mem_model[idx]);
   endtask

   // Called just after a rising edge with both slaves in IDLE; returns the
   // same way after one as_N=1 cycle, i.e. at minimum back-to-back spacing.
   task automatic xfer(input int mode, input logic is_wr, input logic [31:0] addr,
                       input logic [31:0] wdata);
      int idx, lat, lat0, quiet;
      bit seen;
      idx  = int'(addr[ADDR_W+1:2]);
      AD   = addr;
      DO   = wdata;
      wr_N = ~is_wr;
      as_N = 1'b0;
      if (is_wr) mem_model[idx] = wdata;
      else last_di = mem_model[idx];
      sb2.push_back(last_di);
      sb0.push_back(last_di);
      @(posedge CLK); #1;  // capture edge
      if (mode == ModeLatch) begin
         AD   = addr + 32'd4;
         DO   = 32'hFFFF_FFFF;
         wr_N = ~wr_N;
      end
      if (mode == ModeAbandon) as_N = 1'b1;
      seen = 0;
      lat  = -1;
      lat0 = -1;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge CLK);
         if (ack0_n === 1'b0 && lat0 < 0) lat0 = i;
         if (ack_n === 1'b0) begin
            seen = 1;
            lat  = i;
         end
      end
      check_eq("ws2_ack_latency", lat, WS);
      check_eq("ws0_ack_latency", lat0, 0);
      if (mode == ModeHold) begin
         quiet = 0;
         for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            quiet += int'(ack_n === 1'b0) + int'(ack0_n === 1'b0);
            quiet += int'(busy !== 1'b0) + int'(busy0 !== 1'b0);
         end
         check_eq("held_strobe_quiet", quiet, 0);
      end
      @(posedge CLK); #1;
      as_N = 1'b1;
      wr_N = 1'b1;
      @(posedge CLK); #1;
   endtask

   initial begin
      int lows;
      RESET_N  = 1'b0;
      AD       = '0;
      DO       = '0;
      as_N     = 1'b1;
      wr_N     = 1'b1;
      en0      = 1'b1;
      dbg_addr = '0;
      last_di  = '0;
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      check_eq("rst_ack_n", {ack0_n, ack_n}, 2'b11);
      check_eq("rst_busy", {busy0, busy}, 2'b00);
      check_eq("rst_di", DI | DI0, 32'h0);
      RESET_N = 1'b1;
      @(posedge CLK); #1;

      xfer(ModeNormal, 1'b1, 32'h0000_A000, 32'h0011_2233);
      check_dbg(32'h2800);
      xfer(ModeNormal, 1'b0, 32'h0000_A000, 32'h0);
      xfer(ModeHold, 1'b0, 32'h0000_A000, 32'h0);

      xfer(ModeNormal, 1'b1, 32'h0000_A004, 32'h55AA_55AA);
      xfer(ModeNormal, 1'b1, 32'h0000_0100, 32'h0123_0123);
      xfer(ModeNormal, 1'b0, 32'h0000_0100, 32'h0);

      xfer(ModeLatch, 1'b1, 32'h0000_A000, 32'hCAFE_F00D);
      check_dbg(32'h2800);
      check_dbg(32'h2801);

      xfer(ModeAbandon, 1'b1, 32'h0000_0200, 32'h0A0A_0A0A);
      check_dbg(32'h80);

      xfer(ModeNormal, 1'b1, 32'h0000_0014, 32'h0505_0505);
      xfer(ModeNormal, 1'b0, 32'h0000_0100, 32'h0);
      xfer(ModeNormal, 1'b1, 32'h0000_0300, 32'h1357_9BDF);
      check_dbg(32'hC0);

      // Reset during WAIT of a write to word 5; the zero-wait slave sits out.
      en0  = 1'b0;
      AD   = 32'h0000_0014;
      DO   = 32'hDEAD_BEEF;
      wr_N = 1'b0;
      as_N = 1'b0;
      @(posedge CLK); #1;
      as_N = 1'b1;
      wr_N = 1'b1;
      @(negedge CLK);
      RESET_N = 1'b0;
      #1;
      check_eq("midwait_rst_ack_n", ack_n, 1'b1);
      check_eq("midwait_rst_busy", busy, 1'b0);
      check_eq("midwait_rst_di", DI, 32'h0);
      check_eq("midwait_rst_di0", DI0, 32'h0);
      repeat (2) @(negedge CLK);
      RESET_N = 1'b1;
      last_di = '0;
      lows = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge CLK);
         lows += int'(ack_n === 1'b0);
      end
      check_eq("midwait_no_ack", lows, 0);
      en0 = 1'b1;
      @(posedge CLK); #1;
      check_dbg(5);

      xfer(ModeNormal, 1'b0, 32'h0000_A000, 32'h0);
      repeat (2) @(posedge CLK);
      check_eq("sb_drain", sb2.size() + sb0.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
